// File: rtl/lcd_mem_arb.sv
// Three-way arbiter for a single-port LCD pixel memory: display scan-out (requester 0)
// shares the memory with two host writers, with a low-water escalation path for the display.
module lcd_mem_arb #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int BURST = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  input  logic            urgent,
  output logic [2:0]      ack,
  output logic [2:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic            mem_ce,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic [1:0]      owner,
  output logic            busy
);

  localparam logic [7:0] BURST_LAST = 8'(BURST);
  localparam logic [1:0] NONE       = 2'd3;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [1:0]    last_owner;
  logic [7:0]    beat_cnt;
  logic [7:0]    beat_next;
  logic          own_req;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          preempt;
  logic          release_grant;
  logic [1:0]    winner;
  logic          rd_vld_p1;
  logic [1:0]    rd_dst_p1;

  // Rotating priority: the requester after the last grant holder is looked at first.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] pick;
    case (last)
      2'd0:    pick = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
      2'd1:    pick = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
      default: pick = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
    endcase
    return pick;
  endfunction

  always_comb begin
    case (owner)
      2'd0: begin
        own_req   = req[0];
        sel_we    = we[0];
        sel_addr  = addr[0 +: AW];
        sel_wdata = wdata[0 +: DW];
      end
      2'd1: begin
        own_req   = req[1];
        sel_we    = we[1];
        sel_addr  = addr[AW +: AW];
        sel_wdata = wdata[DW +: DW];
      end
      default: begin
        own_req   = req[2];
        sel_we    = we[2];
        sel_addr  = addr[2*AW +: AW];
        sel_wdata = wdata[2*DW +: DW];
      end
    endcase
    ack           = (state == GRANT && own_req) ? (3'b001 << owner) : 3'b000;
    beat_next     = beat_cnt + 8'd1;
    preempt       = (owner != 2'd0) && urgent && req[0];
    release_grant = !own_req || (beat_next == BURST_LAST) || preempt;
    winner        = (urgent && req[0]) ? 2'd0 : rr_pick(req, last_owner);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      owner      <= NONE;
      busy       <= 1'b0;
      last_owner <= 2'd2;
      beat_cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state      <= GRANT;
            owner      <= winner;
            last_owner <= winner;
            beat_cnt   <= 8'd0;
            busy       <= 1'b1;
          end
        end
        GRANT: begin
          if (own_req) beat_cnt <= beat_next;
          if (release_grant) begin
            state <= IDLE;
            owner <= NONE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Stage p1: memory command for the acked beat; read destination follows it
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_vld_p1 <= 1'b0;
      rd_dst_p1 <= 2'd0;
    end else begin
      mem_ce    <= |ack;
      mem_we    <= (|ack) && sel_we;
      rd_vld_p1 <= (|ack) && !sel_we;
      if (|ack) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        rd_dst_p1 <= owner;
      end
    end
  end

  // Stage p2: memory returns data; steer rvalid to the requester that issued the read
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rvalid <= 3'b000;
    end else begin
      rvalid <= rd_vld_p1 ? (3'b001 << rd_dst_p1) : 3'b000;
    end
  end

  assign rdata = (|rvalid) ? mem_rdata : '0;

endmodule

// File: tb/tb_lcd_mem_arb.sv
// Scoreboard bench for lcd_mem_arb: read returns are predicted when a read beat is
// expected to be acked and retired when rvalid appears.
module tb_lcd_mem_arb;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int BURST = 4;

  logic            CLK    = 1'b0;
  logic            nRST   = 1'b0;
  logic [2:0]      req    = '0;
  logic [2:0]      we     = '0;
  logic [3*AW-1:0] addr   = '0;
  logic [3*DW-1:0] wdata  = '0;
  logic            urgent = 1'b0;
  logic [2:0]      ack;
  logic [2:0]      rvalid;
  logic [DW-1:0]   rdata;
  logic            mem_ce;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;
  logic [1:0]      owner;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          due;
    logic [1:0]  dst;
    logic [15:0] data;
  } rd_t;
  rd_t exp_q[$];

  lcd_mem_arb #(.AW(AW), .DW(DW), .BURST(BURST)) dut (
    .CLK(CLK), .nRST(nRST), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .urgent(urgent), .ack(ack), .rvalid(rvalid), .rdata(rdata), .mem_ce(mem_ce),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] pattern(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Synchronous memory: read data appears the cycle after the strobe.
  always @(posedge CLK) if (mem_ce && !mem_we) mem_rdata <= pattern(mem_addr);

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    nRST = 1'b0; req = '0; we = '0; urgent = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; req = 3'b111; urgent = 1'b1; addr = '1; wdata = '1;
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (owner !== 2'd3) begin failures++; $display("FAIL rst_owner got=%0d want=3", owner); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (ack !== 3'b000) begin failures++; $display("FAIL rst_ack got=%b want=000", ack); end
    checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL rst_rvalid got=%b want=000", rvalid); end
    checks++; if ({mem_ce, mem_we, mem_addr, mem_wdata} !== 34'd0) begin
      failures++; $display("FAIL rst_mem got ce=%b we=%b addr=%h wdata=%h want all 0", mem_ce, mem_we, mem_addr, mem_wdata);
    end
    checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL rst_rdata got=%h want=0000", rdata); end
    req = '0; urgent = 1'b0; addr = '0; wdata = '0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_single_read();
    rd_t e;
    logic [2:0] exp_ack;
    logic [2:0] prev_ack;
    int nack;
    exp_q.delete(); prev_ack = '0; nack = 0;
    we = 3'b000; set_addr(0, 16'h0010);
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      req = (k <= 3) ? 3'b001 : 3'b000;
      #1;
      exp_ack = (k >= 1 && k <= 3) ? 3'b001 : 3'b000;
      checks++; if (ack !== exp_ack) begin failures++; $display("FAIL sr_ack k=%0d got=%b want=%b", k, ack, exp_ack); end
      if (k == 1) begin
        checks++; if (owner !== 2'd0) begin failures++; $display("FAIL sr_owner got=%0d want=0", owner); end
      end
      if (prev_ack[0]) begin
        checks++;
        if ({mem_ce, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin
          failures++; $display("FAIL sr_mem k=%0d got ce=%b we=%b addr=%h want ce=1 we=0 addr=0010", k, mem_ce, mem_we, mem_addr);
        end
      end else begin
        checks++; if (mem_ce !== 1'b0) begin failures++; $display("FAIL sr_idle_ce k=%0d got=%b want=0", k, mem_ce); end
      end
      if (ack[0] === 1'b1) nack++;
      if (exp_q.size() > 0 && exp_q[0].due == k) begin
        e = exp_q.pop_front(); checks++;
        if (rvalid !== (3'b001 << e.dst) || rdata !== e.data) begin
          failures++; $display("FAIL sr_rd k=%0d got rvalid=%b rdata=%h want rvalid=%b rdata=%h", k, rvalid, rdata, 3'b001 << e.dst, e.data);
        end
      end else begin
        checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL sr_rvalid k=%0d got=%b want=000", k, rvalid); end
      end
      if (exp_ack[0]) begin
        e.due = k + 2; e.dst = 2'd0; e.data = pattern(16'h0010);
        exp_q.push_back(e);
      end
      prev_ack = exp_ack;
    end
    checks++; if (nack != 3) begin failures++; $display("FAIL sr_count got=%0d want=3", nack); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sr_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_write();
    we = 3'b010; set_addr(1, 16'h0123); wdata[DW +: DW] = 16'hF800;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      req = (k <= 1) ? 3'b010 : 3'b000;
      #1;
      if (k == 1) begin
        checks++; if (ack !== 3'b010 || owner !== 2'd1) begin
          failures++; $display("FAIL wr_grant got ack=%b owner=%0d want ack=010 owner=1", ack, owner);
        end
      end
      if (k == 2) begin
        checks++;
        if ({mem_ce, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h0123, 16'hF800}) begin
          failures++; $display("FAIL wr_mem got ce=%b we=%b addr=%h wdata=%h want ce=1 we=1 addr=0123 wdata=f800", mem_ce, mem_we, mem_addr, mem_wdata);
        end
        checks++; if (ack !== 3'b000) begin failures++; $display("FAIL wr_ack_drop got=%b want=000", ack); end
      end
      if (k == 3) begin
        checks++; if (mem_ce !== 1'b0) begin failures++; $display("FAIL wr_ce_end got=%b want=0", mem_ce); end
      end
      checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL wr_rvalid k=%0d got=%b want=000", k, rvalid); end
    end
  endtask

  task automatic test_round_robin();
    rd_t e;
    logic [1:0] eo;
    logic [2:0] ea;
    int cnt [3];
    do_reset();
    exp_q.delete(); cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
    we = 3'b100;
    set_addr(0, 16'h1000); set_addr(1, 16'h2000); set_addr(2, 16'h3000);
    wdata[2*DW +: DW] = 16'hBEEF;
    for (int k = 0; k < 24; k++) begin
      @(negedge CLK);
      req = (k <= 19) ? 3'b111 : 3'b000;
      #1;
      if (k <= 19 && (k % 5) != 0) begin
        eo = 2'((k / 5) % 3); ea = 3'b001 << eo;
      end else begin
        eo = 2'd3; ea = 3'b000;
      end
      checks++; if (ack !== ea) begin failures++; $display("FAIL rr_ack k=%0d got=%b want=%b", k, ack, ea); end
      checks++; if (owner !== eo) begin failures++; $display("FAIL rr_owner k=%0d got=%0d want=%0d", k, owner, eo); end
      for (int i = 0; i < 3; i++) if (ack[i] === 1'b1) cnt[i]++;
      if (mem_ce === 1'b1 && mem_we === 1'b1) begin
        checks++;
        if (mem_addr !== 16'h3000 || mem_wdata !== 16'hBEEF) begin
          failures++; $display("FAIL rr_wr k=%0d got addr=%h wdata=%h want addr=3000 wdata=beef", k, mem_addr, mem_wdata);
        end
      end
      if (exp_q.size() > 0 && exp_q[0].due == k) begin
        e = exp_q.pop_front(); checks++;
        if (rvalid !== (3'b001 << e.dst) || rdata !== e.data) begin
          failures++; $display("FAIL rr_rd k=%0d got rvalid=%b rdata=%h want rvalid=%b rdata=%h", k, rvalid, rdata, 3'b001 << e.dst, e.data);
        end
      end else begin
        checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL rr_rvalid k=%0d got=%b want=000", k, rvalid); end
      end
      if (ea != 3'b000 && eo != 2'd2) begin
        e.due = k + 2; e.dst = eo; e.data = pattern((eo == 2'd0) ? 16'h1000 : 16'h2000);
        exp_q.push_back(e);
      end
    end
    checks++; if (cnt[0] != 8 || cnt[1] != 4 || cnt[2] != 4) begin
      failures++; $display("FAIL rr_counts got=%0d/%0d/%0d want=8/4/4", cnt[0], cnt[1], cnt[2]);
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rr_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_preempt();
    we = 3'b010; set_addr(1, 16'h0200); wdata[DW +: DW] = 16'h1234; set_addr(0, 16'h0040);
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      case (k)
        0, 1:    begin req = 3'b010; urgent = 1'b0; end
        2, 3:    begin req = 3'b011; urgent = 1'b1; end
        4:       begin req = 3'b001; urgent = 1'b1; end
        default: begin req = 3'b000; urgent = 1'b0; end
      endcase
      #1;
      if (k == 1 || k == 2) begin
        checks++; if (ack !== 3'b010 || owner !== 2'd1) begin
          failures++; $display("FAIL pre_beat k=%0d got ack=%b owner=%0d want ack=010 owner=1", k, ack, owner);
        end
      end
      if (k == 3) begin
        checks++; if (ack !== 3'b000 || owner !== 2'd3 || busy !== 1'b0) begin
          failures++; $display("FAIL pre_idle got ack=%b owner=%0d busy=%b want ack=000 owner=3 busy=0", ack, owner, busy);
        end
        checks++;
        if ({mem_ce, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h0200, 16'h1234}) begin
          failures++; $display("FAIL pre_wr got ce=%b we=%b addr=%h wdata=%h want ce=1 we=1 addr=0200 wdata=1234", mem_ce, mem_we, mem_addr, mem_wdata);
        end
      end
      if (k == 4) begin
        checks++; if (ack !== 3'b001 || owner !== 2'd0 || busy !== 1'b1) begin
          failures++; $display("FAIL pre_win got ack=%b owner=%0d busy=%b want ack=001 owner=0 busy=1", ack, owner, busy);
        end
      end
      if (k == 5) begin
        checks++; if ({mem_ce, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0040}) begin
          failures++; $display("FAIL pre_rdcmd got ce=%b we=%b addr=%h want ce=1 we=0 addr=0040", mem_ce, mem_we, mem_addr);
        end
      end
      if (k == 6) begin
        checks++; if (rvalid !== 3'b001 || rdata !== pattern(16'h0040)) begin
          failures++; $display("FAIL pre_rd got rvalid=%b rdata=%h want rvalid=001 rdata=%h", rvalid, rdata, pattern(16'h0040));
        end
      end
    end
  endtask

  task automatic test_early_release();
    logic [2:0] ea;
    logic [1:0] eo;
    int nack;
    nack = 0;
    we = 3'b100; set_addr(2, 16'h0300); wdata[2*DW +: DW] = 16'h0A0A;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      req = (k <= 1 || (k >= 3 && k <= 7)) ? 3'b100 : 3'b000;
      #1;
      ea = (k == 1 || (k >= 4 && k <= 7)) ? 3'b100 : 3'b000;
      eo = (k == 1 || k == 2 || (k >= 4 && k <= 7)) ? 2'd2 : 2'd3;
      checks++; if (ack !== ea) begin failures++; $display("FAIL er_ack k=%0d got=%b want=%b", k, ack, ea); end
      checks++; if (owner !== eo) begin failures++; $display("FAIL er_owner k=%0d got=%0d want=%0d", k, owner, eo); end
      if (ack[2] === 1'b1) nack++;
    end
    checks++; if (nack != 5) begin failures++; $display("FAIL er_count got=%0d want=5", nack); end
  endtask

  task automatic test_reset_mid_read();
    we = 3'b000; set_addr(0, 16'h0050); urgent = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      req = (k <= 2) ? 3'b001 : 3'b000;
      if (k == 2) nRST = 1'b0;
      if (k == 4) nRST = 1'b1;
      #1;
      if (k == 1) begin
        checks++; if (ack !== 3'b001) begin failures++; $display("FAIL rm_ack got=%b want=001", ack); end
      end
      if (k == 2) begin
        checks++; if (mem_ce !== 1'b0 || owner !== 2'd3 || busy !== 1'b0 || ack !== 3'b000) begin
          failures++; $display("FAIL rm_clear got ce=%b owner=%0d busy=%b ack=%b want ce=0 owner=3 busy=0 ack=000", mem_ce, owner, busy, ack);
        end
      end
      if (k >= 2) begin
        checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL rm_rvalid k=%0d got=%b want=000", k, rvalid); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_preempt();
    test_early_release();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_mem_arb.md
LCD_MEM_ARB -- requirements
Module: lcd_mem_arb

Interface
REQ-001 SHALL have parameter AW, default 16, pixel memory word-address width.
REQ-002 SHALL have parameter DW, default 16, pixel data width (RGB565).
REQ-003 SHALL have parameter BURST, default 16, maximum beats per grant (range 1..255).
REQ-004 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  3  per-requester request; bit 0 is display scan-out, bits 1-2 are host writers.
REQ-007 SHALL have port we  input  3  per-requester write enable, 1=write, 0=read.
REQ-008 SHALL have port addr  input  3*AW  per-requester address; requester i uses bits [i*AW +: AW].
REQ-009 SHALL have port wdata  input  3*DW  per-requester write data; requester i uses bits [i*DW +: DW].
REQ-010 SHALL have port urgent  input  1  display-FIFO low-water flag; escalates requester 0.
REQ-011 SHALL have port ack  output  3  beat accepted for requester i this cycle.
REQ-012 SHALL have port rvalid  output  3  read data valid for requester i.
REQ-013 SHALL have port rdata  output  DW  read data shared by all requesters.
REQ-014 SHALL have port mem_ce  output  1  memory access strobe.
REQ-015 SHALL have port mem_we  output  1  memory write strobe.
REQ-016 SHALL have port mem_addr  output  AW  memory address.
REQ-017 SHALL have port mem_wdata  output  DW  memory write data.
REQ-018 SHALL have port mem_rdata  input  DW  memory read data, valid 1 cycle after mem_ce with mem_we=0.
REQ-019 SHALL have port owner  output  2  current grant holder; 3 = none.
REQ-020 SHALL have port busy  output  1  high in GRANT state.

Function
REQ-021 SHALL implement FSM states IDLE and GRANT.
REQ-022 IDLE: with any req bit high, SHALL select a winner, register owner, clear beat_cnt, and enter GRANT next cycle; no ack is issued in IDLE.
REQ-023 Winner selection: urgent=1 and req[0]=1 SHALL select requester 0; otherwise round-robin starting at (last_owner+1) mod 3.
REQ-024 last_owner SHALL update on each grant and reset to 2, so requester 0 is first in rotation after reset.
REQ-025 GRANT: ack[owner] SHALL be combinationally equal to req[owner]; all other ack bits SHALL be 0.
REQ-026 Each acked beat SHALL increment beat_cnt (8-bit) and drive mem_ce=1 with mem_we, mem_addr, and mem_wdata registered from that requester on the next cycle; mem_ce=0 otherwise.
REQ-027 For an acked read, rvalid[owner] SHALL pulse 2 cycles after the ack and rdata SHALL equal mem_rdata; the rvalid destination SHALL be pipelined, so an owner change never misroutes data.
REQ-028 GRANT SHALL return to IDLE after any cycle in which req[owner]=0, or in which the acked beat makes beat_cnt equal BURST.
REQ-029 Preemption: in GRANT with owner≠0, urgent=1 and req[0]=1, the current cycle's beat SHALL complete and the FSM SHALL return to IDLE next cycle; requester 0 then wins.
REQ-030 Each grant SHALL have one dead IDLE cycle between grants (no back-to-back grants).
REQ-031 Address and data bits SHALL pass through unmodified; no address arithmetic.
REQ-032 A requester that drops req mid-burst loses the grant and SHALL re-arbitrate normally.

Reset
REQ-033 nRST low SHALL asynchronously force IDLE, owner=3, busy=0, ack=0, rvalid=0, mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, beat_cnt=0, and last_owner=2.
REQ-034 Reads in flight at reset assertion SHALL be dropped; no rvalid SHALL follow reset release.

Verification
REQ-035 Single read: req=001, we=0, addr0=0x0010, held 3 beats → owner=0 one cycle later, 3 acks, mem_addr 0x0010 (addr held), rvalid[0] 3 pulses each 2 cycles after its ack.
REQ-036 Round-robin: req=111 held continuously, BURST=4 → grants 0,1,2,0, each exactly 4 acks, one dead cycle between grants.
REQ-037 Preemption: owner=1 writing, urgent=1 and req[0]=1 at beat 2 → beat 2 is written (mem_we=1), then IDLE, then owner=0.
REQ-038 Early release: owner=2, req[2] drops after 1 beat → exactly 1 ack, IDLE next cycle, beat_cnt cleared on the next grant.
REQ-039 Reset mid-read: nRST low 1 cycle after a read ack → mem_ce, rvalid, and owner cleared immediately; no rvalid after release.
REQ-040 Write data: requester 1, we=1, addr=0x0123, wdata=0xF800 → mem_we=1, mem_addr=0x0123, mem_wdata=0xF800 one cycle after the ack; rvalid stays 0.
